// File: rtl/branch_pc_sel_pkg.sv
// Shared encodings for the next-PC selector: PC mux selects and decoded opcodes.
package branch_pc_sel_pkg;

  typedef enum logic [2:0] {
    PCSel_PLUS4     = 3'd0,
    PCSel_ALU       = 3'd1,
    PCSel_PCPLUSIMM = 3'd2,
    PCSel_PCXPLUS4  = 3'd3,
    PCSel_JALR      = 3'd4,
    PCSel_SAME      = 3'd5
  } pc_sel_e;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/branch_pc_sel_counter_table.sv
// Saturating branch counter array: one combinational read port, one write port,
// synchronous reset to weakly-not-taken. Reads see the pre-update value.
module bpc_counter_table #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic [CTR_W-1:0] ctr [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (wr_en) begin
      if (wr_taken) begin
        if (ctr[wr_idx] != CTR_MAX) ctr[wr_idx] <= ctr[wr_idx] + CTR_W'(1);
      end else begin
        if (ctr[wr_idx] != '0) ctr[wr_idx] <= ctr[wr_idx] - CTR_W'(1);
      end
    end
  end

  assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/branch_pc_sel.sv
// Next-PC selector with dynamic branch prediction and performance counters.
// Optional gshare indexing is enabled by defining BPC_GSHARE_EN.
module branch_pc_sel
  import branch_pc_sel_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CTR_W       = 2,
  parameter int unsigned GHR_W       = 6,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [31:0]       fd_pc,
  input  logic [31:0]       fd_inst,
  input  logic              x_valid,
  input  logic              x_is_branch,
  input  logic              x_taken,
  input  logic              x_predicted,
  input  logic [31:0]       x_pc,
  input  logic [GHR_W-1:0]  x_ghr,
  output logic [2:0]        pc_sel,
  output logic              predict,
  output logic [GHR_W-1:0]  fd_ghr,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic             res;
  logic             mis;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] rd_ctr;
  pc_sel_e          sel;
  logic             unused_bits;

  assign res = x_valid & x_is_branch & ~stall;
  assign mis = res & (x_taken != x_predicted);

`ifdef BPC_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  // History advances only on resolved branches, so it is never speculative.
  always_ff @(posedge clk) begin
    if (rst)      ghr <= '0;
    else if (res) ghr <= GHR_W'({ghr, x_taken});
  end

  assign rd_idx      = fd_pc[IDX_W+1:2] ^ IDX_W'(ghr);
  assign wr_idx      = x_pc[IDX_W+1:2] ^ IDX_W'(x_ghr);
  assign fd_ghr      = ghr;
  assign unused_bits = ^{fd_inst[31:7], fd_pc[31:IDX_W+2], fd_pc[1:0],
                         x_pc[31:IDX_W+2], x_pc[1:0]};
`else
  assign rd_idx      = fd_pc[IDX_W+1:2];
  assign wr_idx      = x_pc[IDX_W+1:2];
  assign fd_ghr      = '0;
  assign unused_bits = ^{fd_inst[31:7], fd_pc[31:IDX_W+2], fd_pc[1:0],
                         x_pc[31:IDX_W+2], x_pc[1:0], x_ghr};
`endif

  bpc_counter_table #(
    .ENTRIES (BHT_ENTRIES),
    .CTR_W   (CTR_W),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (res),
    .wr_idx   (wr_idx),
    .wr_taken (x_taken)
  );

  always_comb begin
    sel     = PCSel_PLUS4;
    predict = 1'b0;
    if (rst) begin
      sel = PCSel_PLUS4;
    end else if (stall) begin
      sel = PCSel_SAME;
    end else if (mis) begin
      sel = x_taken ? PCSel_ALU : PCSel_PCXPLUS4;
    end else begin
      case (fd_inst[6:0])
        OPC_JAL:    sel = PCSel_PCPLUSIMM;
        OPC_JALR:   sel = PCSel_JALR;
        OPC_BRANCH: begin
          if (rd_ctr[CTR_W-1]) begin
            sel     = PCSel_PCPLUSIMM;
            predict = 1'b1;
          end
        end
        default:    sel = PCSel_PLUS4;
      endcase
    end
  end

  assign pc_sel = sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else if (res) begin
      perf_branches <= perf_branches + PERF_W'(1);
      if (mis) perf_mispred <= perf_mispred + PERF_W'(1);
    end
  end

endmodule
